rr_arbiter8: RTL and testbench
==============================

Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one downstream resource among 8 requesters, using the same 8-bit request vector, 3-bit index encoding and active-low enable as the team's 8-to-3 priority encoder.
- Adds a registered grant handshake, a rotating priority pointer and a hold-time limit, so no requester can starve the others.
- Sits between the request lines and the shared datapath; `GNT_ID` and `VALID` drive the datapath's select/enable.

Parameters:
- `MAX_HOLD`, 16: maximum consecutive cycles one grant may stay asserted. Legal range 1..255; 0 = unlimited.

Ports:
- `CLK`  input  1  clock; all state changes on the rising edge.
- `RST`  input  1  synchronous reset, active-high.
- `EN`  input  1  arbiter enable, active-low (0 = arbitrate, 1 = disabled).
- `REQ`  input  8  request vector; `REQ[i]` = 1 means requester i wants the resource.
- `GNT`  output  8  one-hot grant, registered.
- `GNT_ID`  output  3  binary index of the granted requester, registered.
- `VALID`  output  1  1 while any grant is active (equals the OR of `GNT`).
- `PTR`  output  3  current round-robin start index, for debug/verification.

Behaviour:
- Reset (`RST` = 1 at a rising edge): `GNT` = 8'h00, `GNT_ID` = 3'b000, `VALID` = 0, `PTR` = 3'b000, hold counter = 0, state = IDLE. Reset overrides everything, including mid-grant.
- States: IDLE, GRANT.
- IDLE, when `EN` = 0 and `REQ` != 0:
  - Select the first set bit scanning from index `PTR` upward, wrapping 7 -> 0.
  - Next edge: state = GRANT, `GNT` = one-hot(sel), `GNT_ID` = sel, `VALID` = 1, counter = 1.
  - Latency: `REQ` sampled at edge k gives the grant visible after edge k.
- IDLE, when `EN` = 1 or `REQ` = 0: outputs stay at 0; `PTR` holds.
- GRANT hold: while `REQ[GNT_ID]` = 1, `EN` = 0 and (`MAX_HOLD` = 0 or counter < `MAX_HOLD`), hold all outputs and increment the counter.
  - The counter saturates at 255 when `MAX_HOLD` = 0.
- GRANT release: triggered when `REQ[GNT_ID]` = 0, or `EN` = 1, or counter = `MAX_HOLD` (`MAX_HOLD` != 0). At the next edge:
  - state = IDLE;
  - `GNT` = 0, `GNT_ID` = 0, `VALID` = 0;
  - `PTR` = `GNT_ID` + 1 mod 8 (7 wraps to 0);
  - counter = 0.
- Each grant is therefore followed by at least one idle cycle. The earliest re-grant is 2 edges after the release condition is sampled.
- Grant length: with `REQ` held, a grant lasts exactly `MAX_HOLD` cycles.
- Other requests: changes to any `REQ` bit other than `GNT_ID` during GRANT are ignored.
- Priority: after reset, `PTR` = 0, so the first arbitration gives lowest index = highest priority, matching the encoder.
- Fairness: any requester holding `REQ` high is granted within 7 grant periods.
- Invariant: `GNT` is always 0 or one-hot, and `GNT[GNT_ID]` = `VALID`.

Test Plan:
- Reset then `EN` = 0, `REQ` = 8'b0010_0100 -> one edge later `GNT` = 8'h04, `GNT_ID` = 2, `VALID` = 1. Drop `REQ[2]` -> next edge `GNT` = 0, `PTR` = 3. Next edge `GNT` = 8'h20, `GNT_ID` = 5.
- Rotation and wrap: `REQ` = 8'hFF held, `MAX_HOLD` = 4 -> grants cycle through `GNT_ID` 0,1,...,7,0. Each grant is 4 cycles high followed by 1 idle cycle. `PTR` wraps 7 -> 0.
- Hold limit: `MAX_HOLD` = 4, `REQ` = 8'h01 held continuously -> `GNT` = 8'h01 for 4 cycles, 0 for 1 cycle, then re-granted (`PTR` = 1 scans and wraps back to 0).
- Enable: `EN` = 1 with `REQ` = 8'h80 -> `GNT` stays 0. `EN` = 0 -> `GNT` = 8'h80. `EN` = 1 mid-grant -> `GNT` = 0 next edge and `PTR` = 0.
- Reset mid-grant: `GNT` = 8'h10 with `PTR` = 4, assert `RST` one cycle -> all outputs 0 and `PTR` = 0. With `REQ` = 8'h11 afterwards -> `GNT` = 8'h01.
- Unlimited hold: `MAX_HOLD` = 0, `REQ` = 8'h08 held 300 cycles -> `GNT` = 8'h08 continuously with no gap, and no counter-overflow release.

Source files
------------

// File: rtl/rr_arbiter8.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter8
// Description : 8-way round-robin arbiter with registered one-hot grant,
//               rotating priority pointer and a per-grant hold-time limit.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic [7:0] REQ,
    output logic [7:0] GNT,
    output logic [2:0] GNT_ID,
    output logic       VALID,
    output logic [2:0] PTR
);

    localparam logic [0:0] c_st_idle   = 1'b0;
    localparam logic [0:0] c_st_grant  = 1'b1;
    localparam logic [7:0] c_max_hold  = MAX_HOLD[7:0];
    localparam bit         c_unlimited = (MAX_HOLD == 0);
    localparam logic [7:0] c_cnt_sat   = 8'hFF;

    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic [7:0] r_gnt;
    logic [2:0] r_gnt_id;
    logic       r_valid;
    logic [2:0] r_ptr;
    logic [7:0] r_cnt;

    logic [7:0] w_gnt_nxt;
    logic [2:0] w_gnt_id_nxt;
    logic       w_valid_nxt;
    logic [2:0] w_ptr_nxt;
    logic [7:0] w_cnt_nxt;

    logic [7:0] w_rot;
    logic [2:0] w_off;
    logic [2:0] w_sel;
    logic [7:0] w_sel_oh;
    logic       w_start;
    logic       w_below_limit;
    logic       w_hold;

    // Request vector viewed from the pointer: w_rot[0] is REQ[PTR].
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_rot
            localparam logic [2:0] c_ofs = 3'(gi);
            assign w_rot[gi] = REQ[c_ofs + r_ptr];
        end
    endgenerate

    always_comb begin
        w_off = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = 3'(i);
            end
        end
    end

    assign w_sel = w_off + r_ptr;

    generate
        for (gi = 0; gi < 8; gi++) begin : g_dec
            localparam logic [2:0] c_idx = 3'(gi);
            assign w_sel_oh[gi] = (w_sel == c_idx);
        end
    endgenerate

    assign w_start       = !EN && (|REQ);
    assign w_below_limit = c_unlimited ? 1'b1 : (r_cnt < c_max_hold);
    assign w_hold        = REQ[r_gnt_id] && !EN && w_below_limit;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= c_st_idle;
            r_gnt    <= 8'h00;
            r_gnt_id <= 3'd0;
            r_valid  <= 1'b0;
            r_ptr    <= 3'd0;
            r_cnt    <= 8'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_gnt_id <= w_gnt_id_nxt;
            r_valid  <= w_valid_nxt;
            r_ptr    <= w_ptr_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (w_start) w_state_nxt = c_st_grant;
            c_st_grant: if (!w_hold) w_state_nxt = c_st_idle;
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    // Every release forces an idle cycle, which is what lets the pointer advance.
    always_comb begin
        w_gnt_nxt    = r_gnt;
        w_gnt_id_nxt = r_gnt_id;
        w_valid_nxt  = r_valid;
        w_ptr_nxt    = r_ptr;
        w_cnt_nxt    = r_cnt;
        case (r_state)
            c_st_idle: begin
                if (w_start) begin
                    w_gnt_nxt    = w_sel_oh;
                    w_gnt_id_nxt = w_sel;
                    w_valid_nxt  = 1'b1;
                    w_cnt_nxt    = 8'd1;
                end
            end
            c_st_grant: begin
                if (w_hold) begin
                    if (r_cnt != c_cnt_sat) begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end else begin
                    w_gnt_nxt    = 8'h00;
                    w_gnt_id_nxt = 3'd0;
                    w_valid_nxt  = 1'b0;
                    w_ptr_nxt    = r_gnt_id + 3'd1;
                    w_cnt_nxt    = 8'd0;
                end
            end
            default: begin
                w_gnt_nxt    = 8'h00;
                w_gnt_id_nxt = 3'd0;
                w_valid_nxt  = 1'b0;
                w_cnt_nxt    = 8'd0;
            end
        endcase
    end

    assign GNT    = r_gnt;
    assign GNT_ID = r_gnt_id;
    assign VALID  = r_valid;
    assign PTR    = r_ptr;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter8.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_arbiter8
// Description : Bench for rr_arbiter8 (MAX_HOLD = 4 and unlimited instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter8;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       EN  = 1'b1;
    logic [7:0] REQ = 8'h00;

    logic [7:0] gnt_a, gnt_b;
    logic [2:0] id_a, id_b, ptr_a, ptr_b;
    logic       valid_a, valid_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    rr_arbiter8 #(.MAX_HOLD(4)) u_dut_h4 (
        .CLK(CLK), .RST(RST), .EN(EN), .REQ(REQ),
        .GNT(gnt_a), .GNT_ID(id_a), .VALID(valid_a), .PTR(ptr_a)
    );

    rr_arbiter8 #(.MAX_HOLD(0)) u_dut_inf (
        .CLK(CLK), .RST(RST), .EN(EN), .REQ(REQ),
        .GNT(gnt_b), .GNT_ID(id_b), .VALID(valid_b), .PTR(ptr_b)
    );

    logic [14:0] obs [2];
    assign obs[0] = {gnt_a, id_a, valid_a, ptr_a};
    assign obs[1] = {gnt_b, id_b, valid_b, ptr_b};

    // Reference model: owner index (-1 = none), start pointer, grant age.
    int mh      [2] = '{4, 0};
    int m_owner [2] = '{-1, -1};
    int m_ptr   [2] = '{0, 0};
    int m_cnt   [2] = '{0, 0};

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            if (RST) begin
                m_owner[d] = -1;
                m_ptr[d]   = 0;
                m_cnt[d]   = 0;
            end else if (m_owner[d] < 0) begin
                if (!EN && REQ != 8'h00) begin
                    for (int k = 0; k < 8; k++) begin
                        int idx;
                        idx = (m_ptr[d] + k) % 8;
                        if (m_owner[d] < 0 && REQ[idx]) begin
                            m_owner[d] = idx;
                            m_cnt[d]   = 1;
                        end
                    end
                end
            end else if (REQ[m_owner[d]] && !EN && (mh[d] == 0 || m_cnt[d] < mh[d])) begin
                if (m_cnt[d] < 255) m_cnt[d]++;
            end else begin
                m_ptr[d]   = (m_owner[d] + 1) % 8;
                m_owner[d] = -1;
                m_cnt[d]   = 0;
            end
        end
    endtask

    function automatic logic [14:0] expv(int d);
        if (m_owner[d] < 0) return {8'h00, 3'd0, 1'b0, 3'(m_ptr[d])};
        return {8'(1 << m_owner[d]), 3'(m_owner[d]), 1'b1, 3'(m_ptr[d])};
    endfunction

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; EN = 1'b1; REQ = 8'h00;
        tick();
        EN = 1'b0; REQ = 8'hFF;
        tick();
        for (int d = 0; d < 2; d++) begin
            n_tests++;
            if (obs[d] !== 15'h0000) begin
                n_fail++;
                $display("FAIL reset dut%0d: got %h want 0000", d, obs[d]);
            end
        end
        REQ = 8'h00;
        RST = 1'b0;
        tick();
        for (int d = 0; d < 2; d++) begin
            n_tests++;
            if (obs[d] !== expv(d)) begin
                n_fail++;
                $display("FAIL reset_idle dut%0d: got %h want %h", d, obs[d], expv(d));
            end
        end
    endtask

    task automatic test_basic();
        EN = 1'b0; REQ = 8'h00;
        do_reset();
        REQ = 8'b0010_0100;
        tick();
        n_tests++;
        if ({gnt_a, id_a, valid_a} !== {8'h04, 3'd2, 1'b1}) begin
            n_fail++;
            $display("FAIL basic_grant: got gnt=%h id=%0d v=%b want 04/2/1", gnt_a, id_a, valid_a);
        end
        REQ = 8'b0010_0000;
        tick();
        n_tests++;
        if ({gnt_a, ptr_a} !== {8'h00, 3'd3}) begin
            n_fail++;
            $display("FAIL basic_release: got gnt=%h ptr=%0d want 00/3", gnt_a, ptr_a);
        end
        tick();
        n_tests++;
        if ({gnt_a, id_a} !== {8'h20, 3'd5}) begin
            n_fail++;
            $display("FAIL basic_regrant: got gnt=%h id=%0d want 20/5", gnt_a, id_a);
        end
        for (int d = 0; d < 2; d++) begin
            n_tests++;
            if (obs[d] !== expv(d)) begin
                n_fail++;
                $display("FAIL basic_model dut%0d: got %h want %h", d, obs[d], expv(d));
            end
        end
    endtask

    task automatic test_rotation();
        int seq[$];
        int run = 0;
        logic prev = 1'b0;
        EN = 1'b0; REQ = 8'h00;
        do_reset();
        REQ = 8'hFF;
        for (int c = 0; c < 50; c++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                n_tests++;
                if (obs[d] !== expv(d)) begin
                    n_fail++;
                    $display("FAIL rotation dut%0d cyc%0d: got %h want %h", d, c, obs[d], expv(d));
                end
            end
            if (valid_a && !prev) seq.push_back(int'(id_a));
            if (valid_a) begin
                run++;
            end else if (run != 0) begin
                n_tests++;
                if (run != 4) begin
                    n_fail++;
                    $display("FAIL rotation_len cyc%0d: got %0d want 4", c, run);
                end
                run = 0;
            end
            prev = valid_a;
        end
        for (int i = 0; i < 9; i++) begin
            n_tests++;
            if (seq.size() <= i || seq[i] != i % 8) begin
                n_fail++;
                $display("FAIL rotation_order idx%0d: got %0d want %0d", i,
                         (seq.size() > i) ? seq[i] : -1, i % 8);
            end
        end
    endtask

    task automatic test_hold_limit();
        logic [10:0] pat = 11'b10111101111;
        EN = 1'b0; REQ = 8'h00;
        do_reset();
        REQ = 8'h01;
        for (int c = 0; c < 11; c++) begin
            tick();
            n_tests++;
            if (gnt_a !== (pat[c] ? 8'h01 : 8'h00)) begin
                n_fail++;
                $display("FAIL hold_limit cyc%0d: got %h want %h", c, gnt_a, pat[c] ? 8'h01 : 8'h00);
            end
            if (c == 4) begin
                n_tests++;
                if (ptr_a !== 3'd1) begin
                    n_fail++;
                    $display("FAIL hold_ptr: got %0d want 1", ptr_a);
                end
            end
            n_tests++;
            if (obs[0] !== expv(0)) begin
                n_fail++;
                $display("FAIL hold_model cyc%0d: got %h want %h", c, obs[0], expv(0));
            end
        end
    endtask

    task automatic test_enable();
        EN = 1'b1; REQ = 8'h00;
        do_reset();
        REQ = 8'h80;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_tests++;
            if ({gnt_a, gnt_b} !== 16'h0000) begin
                n_fail++;
                $display("FAIL enable_off cyc%0d: got %h/%h want 00/00", c, gnt_a, gnt_b);
            end
        end
        EN = 1'b0;
        tick();
        n_tests++;
        if ({gnt_a, id_a} !== {8'h80, 3'd7}) begin
            n_fail++;
            $display("FAIL enable_on: got gnt=%h id=%0d want 80/7", gnt_a, id_a);
        end
        tick();
        EN = 1'b1;
        tick();
        n_tests++;
        if ({gnt_a, valid_a, ptr_a} !== {8'h00, 1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL enable_drop: got gnt=%h v=%b ptr=%0d want 00/0/0", gnt_a, valid_a, ptr_a);
        end
        for (int d = 0; d < 2; d++) begin
            n_tests++;
            if (obs[d] !== expv(d)) begin
                n_fail++;
                $display("FAIL enable_model dut%0d: got %h want %h", d, obs[d], expv(d));
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        EN = 1'b0; REQ = 8'h00;
        do_reset();
        REQ = 8'h08; tick();
        REQ = 8'h00; tick();
        REQ = 8'h10; tick();
        n_tests++;
        if ({gnt_a, ptr_a} !== {8'h10, 3'd4}) begin
            n_fail++;
            $display("FAIL midrst_setup: got gnt=%h ptr=%0d want 10/4", gnt_a, ptr_a);
        end
        RST = 1'b1;
        tick();
        for (int d = 0; d < 2; d++) begin
            n_tests++;
            if (obs[d] !== 15'h0000) begin
                n_fail++;
                $display("FAIL midrst_clear dut%0d: got %h want 0000", d, obs[d]);
            end
        end
        RST = 1'b0;
        REQ = 8'h11;
        tick();
        n_tests++;
        if ({gnt_a, gnt_b} !== 16'h0101) begin
            n_fail++;
            $display("FAIL midrst_regrant: got %h/%h want 01/01", gnt_a, gnt_b);
        end
    endtask

    task automatic test_unlimited();
        int bad = 0;
        EN = 1'b0; REQ = 8'h00;
        do_reset();
        REQ = 8'h08;
        for (int c = 0; c < 301; c++) begin
            tick();
            n_tests++;
            if ({gnt_b, id_b, valid_b} !== {8'h08, 3'd3, 1'b1} || obs[1] !== expv(1)) begin
                n_fail++;
                if (bad < 5) $display("FAIL unlimited cyc%0d: got gnt=%h id=%0d v=%b want 08/3/1",
                                      c, gnt_b, id_b, valid_b);
                bad++;
            end
        end
    endtask

    task automatic test_random();
        int bad = 0;
        EN = 1'b0; REQ = 8'h00;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) REQ = 8'($urandom);
            EN  = ($urandom_range(0, 9) == 0);
            RST = ($urandom_range(0, 149) == 0);
            tick();
            for (int d = 0; d < 2; d++) begin
                n_tests++;
                if (obs[d] !== expv(d)) begin
                    n_fail++;
                    if (bad < 10) $display("FAIL random dut%0d cyc%0d: got %h want %h",
                                           d, c, obs[d], expv(d));
                    bad++;
                end
            end
        end
        RST = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rotation();
        test_hold_limit();
        test_enable();
        test_reset_mid_grant();
        test_unlimited();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
